hazard3_tick_gen: RTL



---
 rtl/hazard3_tick_gen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hazard3_tick_gen.sv
// hazard3_tick_gen: tick strobe for the RISC-V mtime counter, from either an
// integer+fractional clk divider or a forwarded external NRZ reference, APB-configured.
module hazard3_tick_gen #(
  parameter int DIV_INT_RESET  = 12,
  parameter int DIV_FRAC_RESET = 0,
  parameter bit EN_RESET       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        ext_tick,
  output logic        tick
);

  localparam logic [15:0] INT_RST  = 16'(DIV_INT_RESET);
  localparam logic [7:0]  FRAC_RST = 8'(DIV_FRAC_RESET);

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_DIV   = 2'd1;
  localparam logic [1:0] REG_COUNT = 2'd2;
  localparam logic [1:0] REG_TICKS = 2'd3;

  logic        access;
  logic        commit;
  logic        reg_hit;
  logic        xfer_done;
  logic        wr_ctrl;
  logic        wr_div;
  logic        wr_ticks;

  logic        en;
  logic        src;
  logic [15:0] div_int;
  logic [7:0]  div_frac;

  logic [16:0] cnt;
  logic [7:0]  acc;
  logic [8:0]  frac_sum;
  logic        stop_req;
  logic        div_run;
  logic        expire;
  logic        enable_load;

  logic        s1;
  logic        s2;
  logic        s_q;
  logic        ext_fire;

  logic [31:0] ticks;
  logic        unused_bits;

  assign access   = psel && penable;
  assign commit   = access && pready && pwrite;
  assign reg_hit  = (paddr[15:4] == 12'h000);
  assign wr_ctrl  = commit && reg_hit && (paddr[3:2] == REG_CTRL);
  assign wr_div   = commit && reg_hit && (paddr[3:2] == REG_DIV);
  assign wr_ticks = commit && reg_hit && (paddr[3:2] == REG_TICKS);

  assign pslverr     = 1'b0;
  assign unused_bits = ^{paddr[1:0], pwdata[31:24]};

  // A CTRL write that clears EN or selects the external source freezes the
  // divider on its own commit edge, so a coincident expiry is swallowed.
  assign stop_req    = wr_ctrl && (!pwdata[0] || pwdata[1]);
  assign div_run     = en && !src && !stop_req;
  assign expire      = div_run && (cnt == 17'd1);
  assign enable_load = wr_ctrl && !en && pwdata[0];
  assign frac_sum    = {1'b0, acc} + {1'b0, div_frac};

  assign ext_fire = en && src && (s2 != s_q);

  // xfer_done holds pready off until the access phase has been released
  always_ff @(posedge clk) begin
    if (rst) begin
      pready    <= 1'b0;
      xfer_done <= 1'b0;
    end else begin
      pready <= access && !pready && !xfer_done;
      if (!access) begin
        xfer_done <= 1'b0;
      end else if (pready) begin
        xfer_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en       <= EN_RESET;
      src      <= 1'b0;
      div_int  <= INT_RST;
      div_frac <= FRAC_RST;
    end else begin
      if (wr_ctrl) begin
        en  <= pwdata[0];
        src <= pwdata[1];
      end
      if (wr_div) begin
        div_int  <= (pwdata[23:8] == 16'd0) ? 16'd1 : pwdata[23:8];
        div_frac <= pwdata[7:0];
      end
    end
  end

  // The carry out of the fractional accumulator stretches one period by a cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {1'b0, INT_RST};
      acc <= 8'd0;
    end else if (enable_load) begin
      cnt <= {1'b0, div_int};
      acc <= 8'd0;
    end else if (expire) begin
      cnt <= {1'b0, div_int} + {16'd0, frac_sum[8]};
      acc <= frac_sum[7:0];
    end else if (div_run) begin
      cnt <= cnt - 17'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s_q <= 1'b0;
    end else begin
      s1  <= ext_tick;
      s2  <= s1;
      s_q <= s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick  <= 1'b0;
      ticks <= 32'd0;
    end else begin
      tick <= expire || ext_fire;
      if (wr_ticks) begin
        ticks <= 32'd0;
      end else if (tick) begin
        ticks <= ticks + 32'd1;
      end
    end
  end

  always_comb begin
    prdata = 32'd0;
    if (reg_hit) begin
      case (paddr[3:2])
        REG_CTRL:  prdata = {30'd0, src, en};
        REG_DIV:   prdata = {8'd0, div_int, div_frac};
        REG_COUNT: prdata = {15'd0, cnt};
        REG_TICKS: prdata = ticks;
        default:   prdata = 32'd0;
      endcase
    end
  end

endmodule
